// File: rtl/rootmodule_child_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rootmodule_child_scheduler
//  Description : Boot sequencer and round-robin arbiter for the child
//                instances of the root wrapper. Children are enabled one at
//                a time after reset. A single shared resource slot is then
//                granted to one requesting child at a time. Each grant ends
//                on a done strobe from the holder or on a forced timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module rootmodule_child_scheduler #(
    parameter int NUM_CH   = 5,
    parameter int BOOT_GAP = 4,
    parameter int TIMEOUT  = 16,
    localparam int ID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] gnt,
    output logic [ID_W-1:0]   gnt_id,
    output logic              busy,
    output logic              timeout_pulse,
    output logic [ID_W-1:0]   timeout_id
);

    // The boot index has to be able to hold NUM_CH, which marks "all enabled".
    localparam int                  c_bidx_w      = $clog2(NUM_CH + 1);
    localparam logic [7:0]          c_boot_reload = 8'(BOOT_GAP - 1);
    localparam logic [7:0]          c_gnt_last    = 8'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]     c_last_id     = ID_W'(NUM_CH - 1);
    localparam logic [c_bidx_w-1:0] c_boot_done   = c_bidx_w'(NUM_CH);

    localparam logic [1:0] c_st_boot    = 2'd0;
    localparam logic [1:0] c_st_idle    = 2'd1;
    localparam logic [1:0] c_st_grant   = 2'd2;
    localparam logic [1:0] c_st_release = 2'd3;

    logic [1:0]          r_state,      w_state_nxt;
    logic [NUM_CH-1:0]   r_en,         w_en_nxt;
    logic [NUM_CH-1:0]   r_gnt,        w_gnt_nxt;
    logic [ID_W-1:0]     r_gnt_id,     w_gnt_id_nxt;
    logic                r_busy,       w_busy_nxt;
    logic                r_tpulse,     w_tpulse_nxt;
    logic [ID_W-1:0]     r_tid,        w_tid_nxt;
    logic [ID_W-1:0]     r_ptr,        w_ptr_nxt;
    logic [7:0]          r_boot_cnt,   w_boot_cnt_nxt;
    logic [c_bidx_w-1:0] r_boot_idx,   w_boot_idx_nxt;
    logic [7:0]          r_gnt_cnt,    w_gnt_cnt_nxt;

    logic [NUM_CH-1:0]   w_elig;
    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    int                  w_scan;
    logic [ID_W-1:0]     w_ptr_inc;

    assign w_elig    = req & r_en;
    assign w_ptr_inc = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + 1'b1;

    // Round-robin search: first eligible child at or after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_scan = int'(r_ptr) + i;
            if (w_scan >= NUM_CH) begin
                w_scan = w_scan - NUM_CH;
            end
            if (!w_found && w_elig[w_scan[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[ID_W-1:0];
            end
        end
    end

    // Next-state and next-output logic; everything holds unless a state says otherwise.
    always_comb begin
        w_state_nxt    = r_state;
        w_en_nxt       = r_en;
        w_gnt_nxt      = r_gnt;
        w_gnt_id_nxt   = r_gnt_id;
        w_busy_nxt     = r_busy;
        w_tpulse_nxt   = 1'b0;
        w_tid_nxt      = r_tid;
        w_ptr_nxt      = r_ptr;
        w_boot_cnt_nxt = r_boot_cnt;
        w_boot_idx_nxt = r_boot_idx;
        w_gnt_cnt_nxt  = r_gnt_cnt;

        case (r_state)
            c_st_boot: begin
                // Counter at zero means the next enable is due now; the cycle
                // after the last enable moves on to arbitration.
                if (r_boot_idx == c_boot_done) begin
                    w_state_nxt = c_st_idle;
                end else if (r_boot_cnt == 8'd0) begin
                    w_en_nxt[r_boot_idx] = 1'b1;
                    w_boot_idx_nxt       = r_boot_idx + 1'b1;
                    w_boot_cnt_nxt       = c_boot_reload;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt - 8'd1;
                end
            end

            c_st_idle: begin
                if (w_found) begin
                    w_gnt_nxt           = '0;
                    w_gnt_nxt[w_winner] = 1'b1;
                    w_gnt_id_nxt        = w_winner;
                    w_busy_nxt          = 1'b1;
                    w_gnt_cnt_nxt       = 8'd0;
                    w_state_nxt         = c_st_grant;
                end
            end

            c_st_grant: begin
                w_gnt_cnt_nxt = r_gnt_cnt + 8'd1;
                // done from the holder takes priority over an expiring timer.
                if (done[r_gnt_id]) begin
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = c_st_release;
                end else if (r_gnt_cnt == c_gnt_last) begin
                    w_gnt_nxt    = '0;
                    w_busy_nxt   = 1'b0;
                    w_ptr_nxt    = w_ptr_inc;
                    w_tpulse_nxt = 1'b1;
                    w_tid_nxt    = r_gnt_id;
                    w_state_nxt  = c_st_release;
                end
            end

            c_st_release: begin
                w_state_nxt = c_st_idle;
            end

            default: begin
                w_state_nxt = c_st_boot;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_boot;
            r_en       <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_tpulse   <= 1'b0;
            r_tid      <= '0;
            r_ptr      <= '0;
            r_boot_cnt <= 8'd0;
            r_boot_idx <= '0;
            r_gnt_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= w_en_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_busy     <= w_busy_nxt;
            r_tpulse   <= w_tpulse_nxt;
            r_tid      <= w_tid_nxt;
            r_ptr      <= w_ptr_nxt;
            r_boot_cnt <= w_boot_cnt_nxt;
            r_boot_idx <= w_boot_idx_nxt;
            r_gnt_cnt  <= w_gnt_cnt_nxt;
        end
    end

    assign en            = r_en;
    assign gnt           = r_gnt;
    assign gnt_id        = r_gnt_id;
    assign busy          = r_busy;
    assign timeout_pulse = r_tpulse;
    assign timeout_id    = r_tid;

endmodule
`default_nettype wire

// File: tb/tb_rootmodule_child_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rootmodule_child_scheduler
//  Description : Randomized bench for rootmodule_child_scheduler, compared
//                cycle by cycle against a cycle-count based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rootmodule_child_scheduler;

    localparam int c_n   = 5;
    localparam int c_gap = 4;
    localparam int c_to  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] en;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout_pulse;
    logic [2:0] timeout_id;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: time since reset release, current holder and its age.
    int   m_cyc;
    int   m_holder;
    int   m_age;
    int   m_cool;
    int   m_ptr;
    logic m_tp;
    int   m_tid;

    rootmodule_child_scheduler #(
        .NUM_CH   (c_n),
        .BOOT_GAP (c_gap),
        .TIMEOUT  (c_to)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .done          (done),
        .en            (en),
        .gnt           (gnt),
        .gnt_id        (gnt_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse),
        .timeout_id    (timeout_id)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Child k is enabled once 1 + k*gap cycles have elapsed since reset release.
    function automatic logic [4:0] en_of(input int cyc);
        logic [4:0] r;
        r = '0;
        for (int k = 0; k < c_n; k++) begin
            if (cyc >= 1 + k * c_gap) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic rn, input logic [4:0] rq, input logic [4:0] dn);
        logic [4:0] elig;
        int         pick;
        if (!rn) begin
            m_cyc = 0; m_holder = -1; m_age = 0; m_cool = 0;
            m_ptr = 0; m_tp = 1'b0; m_tid = 0;
            return;
        end
        m_tp = 1'b0;
        if (m_holder >= 0) begin
            if (dn[m_holder]) begin
                m_ptr    = (m_holder + 1) % c_n;
                m_holder = -1;
                m_cool   = 1;
            end else if (m_age == c_to - 1) begin
                m_tp     = 1'b1;
                m_tid    = m_holder;
                m_ptr    = (m_holder + 1) % c_n;
                m_holder = -1;
                m_cool   = 1;
            end else begin
                m_age++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_cyc >= 4 * c_gap + 2) begin
            elig = rq & en_of(m_cyc);
            pick = -1;
            for (int i = 0; i < c_n; i++) begin
                if (pick < 0 && elig[(m_ptr + i) % c_n]) pick = (m_ptr + i) % c_n;
            end
            if (pick >= 0) begin
                m_holder = pick;
                m_age    = 0;
            end
        end
        if (m_cyc < 100000) m_cyc++;
    endtask

    // Stimulus, model update and comparison, all paced on the falling edge.
    initial begin
        int         mode;
        logic [4:0] hbit;
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        model_step(1'b0, '0, '0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6000; i++) begin
            mode = (i / 500) % 4;

            check("en", 32'(en), 32'(en_of(m_cyc)));
            check("gnt", 32'(gnt), (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
            check("busy", 32'(busy), (m_holder >= 0) ? 32'd1 : 32'd0);
            if (m_holder >= 0) check("gnt_id", 32'(gnt_id), 32'(m_holder));
            check("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
            check("timeout_id", 32'(timeout_id), 32'(m_tid));

            hbit = (m_holder >= 0) ? 5'(1 << m_holder) : 5'd0;
            rst_n = !(i < 2 || $urandom_range(0, 499) == 0 ||
                      (i % 1000 == 700 && m_holder >= 0));
            case (mode)
                0: begin
                    // All children requesting, each grant answered after 2 cycles.
                    req  = 5'h1F;
                    done = (m_holder >= 0 && m_age == 1) ? hbit : 5'd0;
                end
                1: begin
                    req  = 5'($urandom);
                    done = 5'($urandom) & 5'($urandom);
                end
                2: begin
                    // No releases at all: every grant runs to timeout.
                    req  = 5'($urandom) | 5'h02;
                    done = 5'd0;
                end
                default: begin
                    // Stray done bits on other children; holder releases on the last count.
                    req  = 5'($urandom);
                    done = 5'($urandom) & ~hbit;
                    if (m_holder >= 0 && m_age == c_to - 1) done = done | hbit;
                end
            endcase

            model_step(rst_n, req, done);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
